move_collector: RTL and testbench

//  Board-level drain stage downstream of the eight columnUnit instances.
//  - Round-robin reads each column's 152-bit move FIFO word (8 packed 19-bit moves).
//  - Unpacks each word and drops slots whose invalid flag is set.
//  - Streams the remaining moves one per cycle over a valid/ready handshake to the search/eval stage.
//  - Raises done once every column is done and fully drained.

---
 rtl/move_collector.sv | 211 +++++++++++++++++++++
 tb/tb_move_collector.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_collector.sv
// move_collector: drains the column move FIFOs round-robin, unpacks each
// word, drops invalid slots and streams moves over a valid/ready handshake.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   col_fifo_out    NCOL packed column words, valid the cycle after rden
//   col_fifo_empty  per-column FIFO empty flags
//   col_done        per-column producer done flags
//   col_rden        one-hot single-cycle FIFO read enable
//   move_out        current move (0 when not valid)
//   move_valid      move_out valid
//   move_ready      consumer accepts when valid && ready
//   done            every column done and drained; sticky until reset
//   move_count      accepted moves (statistics)
//   invalid_count   dropped invalid slots (statistics)
//
// Build option: define MOVE_COLLECTOR_STATS_EN to build the two statistics
// counters; when undefined both count ports are tied to 0.

module move_collector #(
  parameter int NCOL           = 8,
  parameter int MOVES_PER_WORD = 8,
  parameter int MOVE_W         = 19,
  parameter int CNT_W          = 12
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NCOL*MOVES_PER_WORD*MOVE_W-1:0]   col_fifo_out,
  input  logic [NCOL-1:0]                         col_fifo_empty,
  input  logic [NCOL-1:0]                         col_done,
  output logic [NCOL-1:0]                         col_rden,
  output logic [MOVE_W-1:0]                       move_out,
  output logic                                    move_valid,
  input  logic                                    move_ready,
  output logic                                    done,
  output logic [CNT_W-1:0]                        move_count,
  output logic [CNT_W-1:0]                        invalid_count
);

  localparam int WORD_W = MOVES_PER_WORD * MOVE_W;
  localparam int PTR_W  = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam int SLOT_W =
    (MOVES_PER_WORD > 1) ? $clog2(MOVES_PER_WORD) : 1;

  typedef enum logic [2:0] {
    S_SCAN,
    S_READ,
    S_LATCH,
    S_UNPACK,
    S_DONE
  } state_e;

  state_e                    state_q, state_d;
  logic [PTR_W-1:0]          rr_q, rr_d;
  logic [PTR_W-1:0]          sel_q, sel_d;
  logic [WORD_W-1:0]         buf_q, buf_d;
  logic [MOVES_PER_WORD-1:0] mask_q, mask_d;

  logic                      found;
  logic [PTR_W-1:0]          pick;
  logic [SLOT_W-1:0]         slot_idx;
  logic [MOVE_W-1:0]         cur_move;
  logic [WORD_W-1:0]         lat_word;
  logic [MOVES_PER_WORD-1:0] inv_vec;
  logic [PTR_W-1:0]          sel_nxt;
  logic                      accept;

  // First non-empty column at or after rr_q. Scanning the offsets from
  // high to low lets the last hit (smallest offset) win without a flag.
  always_comb begin
    found = ~&col_fifo_empty;
    pick  = rr_q;
    for (int k = NCOL - 1; k >= 0; k--) begin
      if (!col_fifo_empty[(int'(rr_q) + k) % NCOL]) begin
        pick = PTR_W'((int'(rr_q) + k) % NCOL);
      end
    end
  end

  // Lowest pending slot of the buffered word.
  always_comb begin
    slot_idx = '0;
    for (int i = MOVES_PER_WORD - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        slot_idx = SLOT_W'(i);
      end
    end
  end

  assign cur_move = buf_q[int'(slot_idx)*MOVE_W +: MOVE_W];
  assign lat_word = col_fifo_out[int'(sel_q)*WORD_W +: WORD_W];

  // Top bit of every slot is its invalid flag.
  always_comb begin
    inv_vec = '0;
    for (int i = 0; i < MOVES_PER_WORD; i++) begin
      inv_vec[i] = lat_word[i*MOVE_W + MOVE_W - 1];
    end
  end

  assign sel_nxt = (sel_q == PTR_W'(NCOL - 1)) ? '0 : sel_q + 1'b1;
  assign accept  = move_valid & move_ready;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    sel_d      = sel_q;
    buf_d      = buf_q;
    mask_d     = mask_q;
    col_rden   = '0;
    move_valid = 1'b0;
    move_out   = '0;
    done       = 1'b0;
    unique case (state_q)
      S_SCAN: begin
        if (found) begin
          sel_d   = pick;
          state_d = S_READ;
        end else if (&col_done) begin
          state_d = S_DONE;
        end
      end
      S_READ: begin
        col_rden[sel_q] = 1'b1;
        state_d         = S_LATCH;
      end
      S_LATCH: begin
        buf_d   = lat_word;
        mask_d  = ~inv_vec;
        state_d = S_UNPACK;
      end
      S_UNPACK: begin
        move_valid = |mask_q;
        move_out   = move_valid ? cur_move : '0;
        if (move_valid && move_ready) begin
          mask_d[slot_idx] = 1'b0;
        end
        // Leaves on the last accept, or at once for an all-invalid word.
        if (mask_d == '0) begin
          rr_d    = sel_nxt;
          state_d = S_SCAN;
        end
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        state_d = S_SCAN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_SCAN;
      rr_q    <= '0;
      sel_q   <= '0;
      buf_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      buf_q   <= buf_d;
      mask_q  <= mask_d;
    end
  end

`ifdef MOVE_COLLECTOR_STATS_EN
  logic [CNT_W-1:0] mcnt_q, mcnt_d;
  logic [CNT_W-1:0] icnt_q, icnt_d;
  logic [CNT_W-1:0] inv_pop;

  always_comb begin
    inv_pop = '0;
    for (int i = 0; i < MOVES_PER_WORD; i++) begin
      inv_pop = inv_pop + CNT_W'(inv_vec[i]);
    end
  end

  always_comb begin
    mcnt_d = mcnt_q;
    icnt_d = icnt_q;
    if (accept) begin
      mcnt_d = mcnt_q + 1'b1;
    end
    if (state_q == S_LATCH) begin
      icnt_d = icnt_q + inv_pop;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcnt_q <= '0;
      icnt_q <= '0;
    end else begin
      mcnt_q <= mcnt_d;
      icnt_q <= icnt_d;
    end
  end

  assign move_count    = mcnt_q;
  assign invalid_count = icnt_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign move_count    = '0;
  assign invalid_count = '0;
`endif

endmodule

// File: tb/tb_move_collector.sv
// tb_move_collector: randomized bench for move_collector with a
// transaction-level round-robin model and per-cycle output compare.

module tb_move_collector;

  localparam int NCOL = 8;
  localparam int MW   = 19;
  localparam int CW   = 12;
  localparam int WW   = 152;
  localparam int DEP  = 16;
`ifdef MOVE_COLLECTOR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [NCOL*WW-1:0] col_fifo_out;
  logic [NCOL-1:0]   col_fifo_empty;
  logic [NCOL-1:0]   col_done;
  logic [NCOL-1:0]   col_rden;
  logic [MW-1:0]     move_out;
  logic              move_valid;
  logic              move_ready;
  logic              done;
  logic [CW-1:0]     move_count;
  logic [CW-1:0]     invalid_count;

  move_collector dut (
    .clk           (clk),
    .reset         (reset),
    .col_fifo_out  (col_fifo_out),
    .col_fifo_empty(col_fifo_empty),
    .col_done      (col_done),
    .col_rden      (col_rden),
    .move_out      (move_out),
    .move_valid    (move_valid),
    .move_ready    (move_ready),
    .done          (done),
    .move_count    (move_count),
    .invalid_count (invalid_count)
  );

  always #5 clk = ~clk;

  // Upstream column FIFOs: words written by the stimulus, popped on rden.
  logic [WW-1:0] mem [NCOL][DEP];
  int cnt_push [NCOL];
  int cnt_pop  [NCOL];

  always_comb begin
    for (int c = 0; c < NCOL; c++) begin
      col_fifo_empty[c] = (cnt_push[c] == cnt_pop[c]);
    end
  end

  always @(posedge clk) begin
    for (int c = 0; c < NCOL; c++) begin
      if (reset) begin
        cnt_pop[c] <= cnt_push[c];
        col_fifo_out[c*WW +: WW] <= '0;
      end else if (col_rden[c] && cnt_pop[c] != cnt_push[c]) begin
        col_fifo_out[c*WW +: WW] <= mem[c][cnt_pop[c] % DEP];
        cnt_pop[c] <= cnt_pop[c] + 1;
      end
    end
  end

  // Model state.
  logic [WW-1:0] mq [NCOL][$];
  logic [MW-1:0] exp_moves [$];
  int            exp_cols [$];
  int            rden_log [$];
  int            rden_t [$];
  int            m_rr;
  logic [CW-1:0] m_inv;
  int            mv_rd;
  int            col_rd;
  int            m_acc;
  int            cyc;
  int            act_c;
  int            ec;
  bit            prev_stall;
  logic [MW-1:0] prev_move;
  bit            stop;
  int            n_chk;
  int            n_fail;
  int            ord [4] = '{1, 6, 1, 6};

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WW-1:0] mk_word(input logic [7:0] inv);
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      w[i*MW +: MW] = {inv[i], 18'($urandom)};
    end
    return w;
  endfunction

  task automatic push(input int c, input logic [WW-1:0] w);
    mem[c][cnt_push[c] % DEP] = w;
    cnt_push[c] = cnt_push[c] + 1;
    mq[c].push_back(w);
  endtask

  // Round-robin at word granularity: next non-empty column from m_rr,
  // one word per visit, valid slots in ascending order.
  task automatic plan();
    bit            any;
    int            c;
    logic [WW-1:0] w;
    do begin
      any = 1'b0;
      for (int k = 0; k < NCOL; k++) begin
        c = (m_rr + k) % NCOL;
        if (!any && mq[c].size() > 0) begin
          any = 1'b1;
          w = mq[c].pop_front();
          exp_cols.push_back(c);
          for (int i = 0; i < 8; i++) begin
            if (w[i*MW + MW - 1]) m_inv = m_inv + 1'b1;
            else exp_moves.push_back(w[i*MW +: MW]);
          end
          m_rr = (c + 1) % NCOL;
        end
      end
    end while (any);
  endtask

  task automatic drive_ready(input bit rnd);
    move_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic wait_idle(input bit rnd);
    int n;
    n = 0;
    while ((mv_rd < exp_moves.size() || col_rd < exp_cols.size())
           && n < 3000) begin
      drive_ready(rnd);
      step();
      n++;
    end
    chk("idle_timeout", longint'(n < 3000), 1);
    move_ready = 1'b1;
    repeat (5) step();
    chk("invalid_count", invalid_count, STATS ? m_inv : 0);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCOL; c++) mq[c].delete();
    m_rr  = 0;
    m_inv = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic compare_loop();
    while (!stop) begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        mv_rd      = exp_moves.size();
        col_rd     = exp_cols.size();
        m_acc      = 0;
        prev_stall = 1'b0;
      end else begin
        if (col_rden != '0) begin
          ec = (col_rd < exp_cols.size()) ? exp_cols[col_rd] : -1;
          chk("rden", col_rden, (ec >= 0) ? (1 << ec) : 0);
          act_c = -1;
          for (int c = 0; c < NCOL; c++) begin
            if (col_rden[c]) act_c = c;
          end
          rden_log.push_back(act_c);
          rden_t.push_back(cyc);
          col_rd++;
        end
        if (prev_stall) begin
          chk("hold_valid", move_valid, 1);
          chk("hold_data", move_out, prev_move);
        end
        if (move_valid) begin
          if (mv_rd < exp_moves.size())
            chk("move", move_out, exp_moves[mv_rd]);
          else
            chk("spurious_valid", move_valid, 0);
        end
        chk("move_count", move_count, STATS ? (m_acc % 4096) : 0);
        if (move_valid && move_ready) begin
          m_acc++;
          if (mv_rd < exp_moves.size()) mv_rd++;
        end
        if (done) begin
          chk("early_done",
              longint'(mv_rd < exp_moves.size() ||
                       col_rd < exp_cols.size()), 0);
        end
        prev_stall = move_valid && !move_ready;
        prev_move  = move_out;
      end
    end
  endtask

  task automatic stimulus();
    logic [WW-1:0] w;
    logic [WW-1:0] w5;
    logic [7:0]    inv;
    logic [CW-1:0] inv_pre;
    int            base;
    int            n;
    int            nw;

    // Reset and idle.
    reset      = 1'b1;
    move_ready = 1'b0;
    col_done   = '0;
    step();
    step();
    reset = 1'b0;
    repeat (20) begin
      step();
      chk("idle_rden", col_rden, 0);
      chk("idle_valid", move_valid, 0);
      chk("idle_done", done, 0);
    end

    // Column 3, slots 0,2,5 valid, latency and ordering.
    move_ready = 1'b1;
    w = mk_word(8'b1101_1010);
    push(3, w);
    plan();
    chk("pin_col3", exp_cols[exp_cols.size()-1], 3);
    chk("pin_n3", exp_moves.size(), 3);
    chk("pin_m0", exp_moves[0], w[0*MW +: MW]);
    chk("pin_m5", exp_moves[2], w[5*MW +: MW]);
    step();
    chk("t2_rden", col_rden, 8'h08);
    step();
    chk("t2_latch_rden", col_rden, 0);
    chk("t2_latch_valid", move_valid, 0);
    step();
    chk("t2_v0", move_valid, 1);
    chk("t2_m0", move_out, w[0*MW +: MW]);
    step();
    chk("t2_m2", move_out, w[2*MW +: MW]);
    step();
    chk("t2_m5", move_out, w[5*MW +: MW]);
    step();
    chk("t2_end_valid", move_valid, 0);
    chk("t2_mcnt", move_count, STATS ? 3 : 0);
    chk("t2_icnt", invalid_count, STATS ? 5 : 0);
    wait_idle(1'b0);

    // Columns 1 and 6 with two words each, fairness from rr=0.
    do_reset();
    base = rden_log.size();
    push(1, mk_word(8'h00));
    push(1, mk_word(8'h00));
    push(6, mk_word(8'h00));
    push(6, mk_word(8'h00));
    plan();
    for (int i = 0; i < 4; i++) begin
      chk("pin_order", exp_cols[exp_cols.size()-4+i], ord[i]);
    end
    wait_idle(1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("t3_order", rden_log[base+i], ord[i]);
    end
    chk("t3_total", m_acc, 32);

    // Stall for 5 cycles mid-word on column 2.
    move_ready = 1'b0;
    w = mk_word(8'h00);
    push(2, w);
    plan();
    n = 0;
    while (!move_valid && n < 20) begin
      step();
      n++;
    end
    chk("t4_valid_seen", move_valid, 1);
    move_ready = 1'b1;
    step();
    step();
    move_ready = 1'b0;
    repeat (5) begin
      step();
      chk("t4_stall_valid", move_valid, 1);
      chk("t4_stall_data", move_out, w[2*MW +: MW]);
      chk("t4_stall_rden", col_rden, 0);
    end
    wait_idle(1'b0);
    chk("t4_total", m_acc, 40);

    // All-invalid word in column 4 followed by column 5.
    inv_pre = m_inv;
    inv = 8'($urandom);
    base = rden_t.size();
    push(4, mk_word(8'hFF));
    w5 = mk_word(inv);
    push(5, w5);
    plan();
    chk("pin_inv",
        m_inv - inv_pre, 8 + $countones(inv));
    wait_idle(1'b0);
    chk("t5_first_col", rden_log[base], 4);
    chk("t5_gap", rden_t[base+1] - rden_t[base], 4);
    chk("t5_icnt", invalid_count,
        STATS ? (inv_pre + 8 + $countones(inv)) % 4096 : 0);

    // Randomized traffic with random backpressure.
    repeat (25) begin
      for (int c = 0; c < NCOL; c++) begin
        if ($urandom_range(0, 2) == 0) begin
          nw = $urandom_range(1, 3);
          for (int j = 0; j < nw; j++) begin
            case ($urandom_range(0, 3))
              0:       inv = 8'h00;
              1:       inv = 8'hFF;
              default: inv = 8'($urandom);
            endcase
            push(c, mk_word(inv));
          end
        end
      end
      plan();
      wait_idle(1'b1);
    end

    // Done with column 0 still holding a word.
    col_done = '1;
    push(0, mk_word(8'h0F));
    plan();
    n = 0;
    while (!done && n < 200) begin
      drive_ready(1'b1);
      step();
      n++;
    end
    chk("t6_done", done, 1);
    chk("t6_drained", exp_moves.size() - mv_rd, 0);
    move_ready = 1'b1;
    repeat (5) step();
    chk("t6_sticky", done, 1);

    // Reset in the middle of a word.
    col_done = '0;
    do_reset();
    move_ready = 1'b0;
    push(0, mk_word(8'h80));
    plan();
    n = 0;
    while (!move_valid && n < 20) begin
      step();
      n++;
    end
    chk("t6_valid_seen", move_valid, 1);
    move_ready = 1'b1;
    step();
    move_ready = 1'b0;
    reset = 1'b1;
    model_reset();
    step();
    chk("rst_rden", col_rden, 0);
    chk("rst_valid", move_valid, 0);
    chk("rst_move", move_out, 0);
    chk("rst_done", done, 0);
    chk("rst_mcnt", move_count, 0);
    chk("rst_icnt", invalid_count, 0);
    reset = 1'b0;
    repeat (6) step();
    chk("post_rst_valid", move_valid, 0);
    chk("post_rst_done", done, 0);

    stop = 1'b1;
    step();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    stop   = 1'b0;
    cyc    = 0;
    m_rr   = 0;
    m_inv  = '0;
    mv_rd  = 0;
    col_rd = 0;
    m_acc  = 0;
    prev_stall = 1'b0;
    prev_move  = '0;
    reset      = 1'b1;
    move_ready = 1'b0;
    col_done   = '0;
    fork
      compare_loop();
      stimulus();
    join
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
